pio_irq_service_master: RTL and testbench

Avalon-MM initiator that owns the far end of a single-bit edge-capturing PIO input slave (data at offset 0, irq mask at offset 2, edge capture at offset 3, fixed 1-cycle read latency, no waitrequest). It arms the slave's interrupt mask, services each rising-edge interrupt, and presents the serviced event on a valid/ready stream. Sits between the LFSR-clock PIO slave and fabric logic that consumes edge events without a Nios II in the loop.

---
 rtl/pio_irq_svc_pkg.sv | 20 ++
 rtl/pio_irq_svc_evt_buf.sv | 72 +++++++
 rtl/pio_irq_service_master.sv | 139 +++++++++++++
 tb/tb_pio_irq_service_master.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pio_irq_svc_pkg.sv
// rtl/pio_irq_svc_pkg.sv - shared types and PIO slave register offsets for the irq service master
package pio_irq_svc_pkg;

    typedef enum logic [3:0] {
        DISARMED,
        ARM,
        IDLE,
        RD_CAP,
        WAIT_CAP,
        CLR,
        RD_DATA,
        WAIT_DATA,
        DISARM
    } state_t;

    localparam logic [1:0] PIO_OFS_DATA = 2'd0;
    localparam logic [1:0] PIO_OFS_MASK = 2'd2;
    localparam logic [1:0] PIO_OFS_EDGE = 2'd3;

endpackage

// File: rtl/pio_irq_svc_evt_buf.sv
// rtl/pio_irq_svc_evt_buf.sv - single-entry event output register with sequence and saturating drop counters
// Optional timestamp storage under PIO_IRQ_SVC_TIMESTAMP_EN.
module pio_irq_svc_evt_buf #(
    parameter int SEQ_W = 16,
    parameter int OVF_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_push,
    input  logic             i_level,
`ifdef PIO_IRQ_SVC_TIMESTAMP_EN
    input  logic [31:0]      i_timestamp,
    output logic [31:0]      o_timestamp,
`endif
    input  logic             i_ready,
    output logic             o_valid,
    output logic             o_level,
    output logic [SEQ_W-1:0] o_seq,
    output logic [OVF_W-1:0] o_ovf_count
);

    logic             r_valid;
    logic             r_level;
    logic [SEQ_W-1:0] r_seq;
    logic [SEQ_W-1:0] r_next_seq;
    logic [OVF_W-1:0] r_ovf;
    logic             w_accept;

    // The slot frees in the same cycle the consumer takes the held event.
    assign w_accept = !r_valid || i_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid    <= 1'b0;
            r_level    <= 1'b0;
            r_seq      <= '0;
            r_next_seq <= '0;
            r_ovf      <= '0;
        end else if (i_push) begin
            if (w_accept) begin
                r_valid    <= 1'b1;
                r_level    <= i_level;
                r_seq      <= r_next_seq;
                r_next_seq <= r_next_seq + 1'b1;
            end else if (r_ovf != '1) begin
                r_ovf <= r_ovf + 1'b1;
            end
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

`ifdef PIO_IRQ_SVC_TIMESTAMP_EN
    logic [31:0] r_timestamp;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_timestamp <= '0;
        end else if (i_push && w_accept) begin
            r_timestamp <= i_timestamp;
        end
    end

    assign o_timestamp = r_timestamp;
`endif

    assign o_valid     = r_valid;
    assign o_level     = r_level;
    assign o_seq       = r_seq;
    assign o_ovf_count = r_ovf;

endmodule

// File: rtl/pio_irq_service_master.sv
// rtl/pio_irq_service_master.sv - Avalon-MM initiator that arms and services an edge-capture PIO slave irq
// Define PIO_IRQ_SVC_TIMESTAMP_EN to add the evt_timestamp cycle-stamp output.
module pio_irq_service_master
    import pio_irq_svc_pkg::*;
#(
    parameter int SEQ_W = 16,
    parameter int OVF_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             irq,
    output logic [1:0]       avm_address,
    output logic             avm_chipselect,
    output logic             avm_write_n,
    output logic [31:0]      avm_writedata,
    input  logic [31:0]      avm_readdata,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic             evt_level,
    output logic [SEQ_W-1:0] evt_seq,
    output logic [OVF_W-1:0] ovf_count,
`ifdef PIO_IRQ_SVC_TIMESTAMP_EN
    output logic [31:0]      evt_timestamp,
`endif
    output logic             armed
);

    state_t r_state;
    logic   r_armed;
    logic   w_push;
    logic   w_unused_rd;

    assign w_unused_rd = ^avm_readdata[31:1];

`ifdef PIO_IRQ_SVC_TIMESTAMP_EN
    logic [31:0] r_cycle;
    logic [31:0] r_ts_cap;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cycle  <= '0;
            r_ts_cap <= '0;
        end else begin
            r_cycle <= r_cycle + 32'd1;
            if (r_state == IDLE && enable && irq) begin
                r_ts_cap <= r_cycle;
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= DISARMED;
            r_armed <= 1'b0;
        end else begin
            case (r_state)
                DISARMED:  if (enable) r_state <= ARM;
                ARM: begin
                    r_state <= IDLE;
                    r_armed <= 1'b1;
                end
                // Disarm wins over a pending irq; mid-service drops of enable land here afterwards.
                IDLE: begin
                    if (!enable)   r_state <= DISARM;
                    else if (irq)  r_state <= RD_CAP;
                end
                RD_CAP:    r_state <= WAIT_CAP;
                WAIT_CAP:  r_state <= avm_readdata[0] ? CLR : IDLE;
                CLR:       r_state <= RD_DATA;
                RD_DATA:   r_state <= WAIT_DATA;
                WAIT_DATA: r_state <= IDLE;
                DISARM: begin
                    r_state <= DISARMED;
                    r_armed <= 1'b0;
                end
                default:   r_state <= DISARMED;
            endcase
        end
    end

    always_comb begin
        avm_chipselect = 1'b0;
        avm_write_n    = 1'b1;
        avm_address    = PIO_OFS_DATA;
        avm_writedata  = '0;
        case (r_state)
            ARM: begin
                avm_chipselect = 1'b1;
                avm_write_n    = 1'b0;
                avm_address    = PIO_OFS_MASK;
                avm_writedata  = 32'd1;
            end
            DISARM: begin
                avm_chipselect = 1'b1;
                avm_write_n    = 1'b0;
                avm_address    = PIO_OFS_MASK;
            end
            RD_CAP: begin
                avm_chipselect = 1'b1;
                avm_address    = PIO_OFS_EDGE;
            end
            CLR: begin
                avm_chipselect = 1'b1;
                avm_write_n    = 1'b0;
                avm_address    = PIO_OFS_EDGE;
            end
            RD_DATA: begin
                avm_chipselect = 1'b1;
                avm_address    = PIO_OFS_DATA;
            end
            default: ;
        endcase
    end

    assign w_push = (r_state == WAIT_DATA);
    assign armed  = r_armed;

    pio_irq_svc_evt_buf #(
        .SEQ_W(SEQ_W),
        .OVF_W(OVF_W)
    ) u_evt_buf (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_push      (w_push),
        .i_level     (avm_readdata[0]),
`ifdef PIO_IRQ_SVC_TIMESTAMP_EN
        .i_timestamp (r_ts_cap),
        .o_timestamp (evt_timestamp),
`endif
        .i_ready     (evt_ready),
        .o_valid     (evt_valid),
        .o_level     (evt_level),
        .o_seq       (evt_seq),
        .o_ovf_count (ovf_count)
    );

endmodule

// File: tb/tb_pio_irq_service_master.sv
// tb/tb_pio_irq_service_master.sv - self-checking bench with an edge-capture PIO slave model
module tb_pio_irq_service_master;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic        irq;
    logic [1:0]  avm_address;
    logic        avm_chipselect;
    logic        avm_write_n;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata;
    logic        evt_valid;
    logic        evt_ready = 1'b0;
    logic        evt_level;
    logic [15:0] evt_seq;
    logic [7:0]  ovf_count;
    logic        armed;
`ifdef PIO_IRQ_SVC_TIMESTAMP_EN
    logic [31:0] evt_timestamp;
`endif

    always #5 clk = ~clk;

    pio_irq_service_master #(.SEQ_W(16), .OVF_W(8)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .enable         (enable),
        .irq            (irq),
        .avm_address    (avm_address),
        .avm_chipselect (avm_chipselect),
        .avm_write_n    (avm_write_n),
        .avm_writedata  (avm_writedata),
        .avm_readdata   (avm_readdata),
        .evt_valid      (evt_valid),
        .evt_ready      (evt_ready),
        .evt_level      (evt_level),
        .evt_seq        (evt_seq),
        .ovf_count      (ovf_count),
`ifdef PIO_IRQ_SVC_TIMESTAMP_EN
        .evt_timestamp  (evt_timestamp),
`endif
        .armed          (armed)
    );

    // Edge-capturing PIO slave: data @0, irq mask @2, edge capture @3, 1-cycle read latency.
    logic in_port = 1'b0;
    logic force_irq = 1'b0;
    logic s_mask, s_edge, s_prev;
    logic [31:0] s_rdata;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s_mask <= 1'b0; s_edge <= 1'b0; s_prev <= 1'b0; s_rdata <= '0;
        end else begin
            s_prev <= in_port;
            if (in_port && !s_prev) s_edge <= 1'b1;
            else if (avm_chipselect && !avm_write_n && avm_address == 2'd3) s_edge <= 1'b0;
            if (avm_chipselect && !avm_write_n && avm_address == 2'd2) s_mask <= avm_writedata[0];
            if (avm_chipselect && avm_write_n)
                case (avm_address)
                    2'd0:    s_rdata <= {31'd0, in_port};
                    2'd2:    s_rdata <= {31'd0, s_mask};
                    2'd3:    s_rdata <= {31'd0, s_edge};
                    default: s_rdata <= '0;
                endcase
        end
    end

    assign irq = (s_edge & s_mask) | force_irq;
    assign avm_readdata = s_rdata;

    // Bus traffic counters per offset.
    int n_rd [4];
    int n_wr [4];

    always @(posedge clk) begin
        if (reset_n && avm_chipselect) begin
            if (!avm_write_n) n_wr[avm_address] = n_wr[avm_address] + 1;
            else              n_rd[avm_address] = n_rd[avm_address] + 1;
        end
    end

    task automatic clr_mon();
        for (int i = 0; i < 4; i++) begin n_rd[i] = 0; n_wr[i] = 0; end
    endtask

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model of the event stream: an output slot plus pending pushes scheduled per edge.
    int  cyc = 0;
    bit  model_on = 0;
    bit  m_occ = 0;
    bit  m_level = 0;
    int  m_seq = 0;
    int  m_next = 0;
    int  m_ovf = 0;
    int  pend_t [$];
    bit  pend_l [$];

    task automatic model_step();
        if (pend_t.size() > 0 && pend_t[0] == cyc) begin
            if (!m_occ || evt_ready) begin
                m_occ = 1; m_level = pend_l[0]; m_seq = m_next % 65536; m_next++;
            end else if (m_ovf < 255) begin
                m_ovf++;
            end
            void'(pend_t.pop_front());
            void'(pend_l.pop_front());
        end else if (evt_ready) begin
            m_occ = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        if (model_on) model_step();
        #1;
    endtask

    // Rising edge on in_port; the pulse lasts `hold` cycles (7 keeps level 1 at the data read, 1 gives level 0).
    task automatic do_event(input int hold, input bit rdy);
        evt_ready = rdy;
        in_port = 1'b1;
        for (int j = 1; j <= 7; j++) begin
            tick();
            if (j == hold) in_port = 1'b0;
        end
        in_port = 1'b0;
    endtask

    typedef struct {
        int hold;
        bit ready;
        bit exp_valid;
        bit exp_level;
        int exp_seq;
        int exp_ovf;
    } vec_t;

    vec_t vecs [6];

    initial begin
        vecs[0] = '{7, 1'b1, 1'b1, 1'b1, 0, 0};
        vecs[1] = '{1, 1'b0, 1'b1, 1'b0, 1, 0};
        vecs[2] = '{7, 1'b0, 1'b1, 1'b0, 1, 1};
        vecs[3] = '{7, 1'b0, 1'b1, 1'b0, 1, 2};
        vecs[4] = '{7, 1'b1, 1'b1, 1'b1, 2, 2};
        vecs[5] = '{1, 1'b1, 1'b1, 1'b0, 3, 2};

        clr_mon();
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", evt_valid, 0);
        check("rst_level", evt_level, 0);
        check("rst_seq", evt_seq, 0);
        check("rst_ovf", ovf_count, 0);
        check("rst_armed", armed, 0);
        check("rst_cs", avm_chipselect, 0);
        check("rst_wn", avm_write_n, 1);
        check("rst_addr", avm_address, 0);
        check("rst_wdata", avm_writedata, 0);

        enable = 1'b1;
        reset_n = 1'b1;
        clr_mon();
        tick();
        check("arm_cs", avm_chipselect, 1);
        check("arm_wn", avm_write_n, 0);
        check("arm_addr", avm_address, 2);
        check("arm_wdata", avm_writedata, 1);
        check("arm_armed_early", armed, 0);
        tick();
        check("arm_armed", armed, 1);
        check("arm_idle_cs", avm_chipselect, 0);
        repeat (3) tick();
        check("arm_wr2", n_wr[2], 1);
        check("arm_other", n_wr[0] + n_wr[1] + n_wr[3] + n_rd[0] + n_rd[1] + n_rd[2] + n_rd[3], 0);

        for (int v = 0; v < 6; v++) begin
            clr_mon();
            do_event(vecs[v].hold, vecs[v].ready);
            check($sformatf("vec%0d_valid", v), evt_valid, vecs[v].exp_valid);
            check($sformatf("vec%0d_level", v), evt_level, vecs[v].exp_level);
            check($sformatf("vec%0d_seq", v), evt_seq, vecs[v].exp_seq);
            check($sformatf("vec%0d_ovf", v), ovf_count, vecs[v].exp_ovf);
            check($sformatf("vec%0d_bus", v), {n_rd[3][7:0], n_wr[3][7:0], n_rd[0][7:0]}, 24'h010101);
            repeat (2) tick();
        end
        check("ready_drops_valid", evt_valid, 0);

        evt_ready = 1'b0;
        clr_mon();
        force_irq = 1'b1;
        tick();
        force_irq = 1'b0;
        repeat (5) tick();
        check("spur_rd3", n_rd[3], 1);
        check("spur_rd0", n_rd[0], 0);
        check("spur_wr", n_wr[0] + n_wr[2] + n_wr[3], 0);
        check("spur_valid", evt_valid, 0);
        check("spur_ovf", ovf_count, 2);

        clr_mon();
        evt_ready = 1'b1;
        in_port = 1'b1;
        repeat (4) tick();
        enable = 1'b0;
        repeat (3) tick();
        in_port = 1'b0;
        check("dis_valid", evt_valid, 1);
        check("dis_level", evt_level, 1);
        check("dis_seq", evt_seq, 4);
        check("dis_armed_hold", armed, 1);
        tick();
        check("dis_cs", avm_chipselect, 1);
        check("dis_wn", avm_write_n, 0);
        check("dis_addr", avm_address, 2);
        check("dis_wdata", avm_writedata, 0);
        tick();
        check("dis_armed", armed, 0);
        check("dis_idle_cs", avm_chipselect, 0);
        check("dis_bus", {n_rd[3][7:0], n_wr[3][7:0], n_rd[0][7:0], n_wr[2][7:0]}, 32'h01010101);

        enable = 1'b1;
        repeat (2) tick();
        check("rearm_armed", armed, 1);
        in_port = 1'b1;
        repeat (4) tick();
        check("clr_state_addr", {avm_chipselect, avm_write_n, avm_address}, 4'b1011);
        reset_n = 1'b0;
        #1;
        check("rclr_cs", avm_chipselect, 0);
        check("rclr_armed", armed, 0);
        check("rclr_valid", evt_valid, 0);
        check("rclr_seq", evt_seq, 0);
        check("rclr_ovf", ovf_count, 0);
        in_port = 1'b0;
        evt_ready = 1'b0;
        tick();
        reset_n = 1'b1;
        clr_mon();
        tick();
        check("rclr_arm", {avm_chipselect, avm_write_n, avm_address, avm_writedata[3:0]}, 8'b1010_0001);
        tick();
        check("rclr_armed_again", armed, 1);

        model_on = 1;
        for (int e = 0; e < 40; e++) begin
            int hold;
            int sp;
            hold = ($urandom_range(0, 1) == 1) ? 7 : 1;
            sp = 8 + $urandom_range(0, 5);
            in_port = 1'b1;
            pend_t.push_back(cyc + 7);
            pend_l.push_back(hold == 7);
            for (int j = 1; j <= sp; j++) begin
                evt_ready = $urandom_range(0, 1);
                tick();
                if (j == hold) in_port = 1'b0;
                check("rnd_valid", evt_valid, m_occ);
                check("rnd_ovf", ovf_count, m_ovf);
                if (m_occ) check("rnd_evt", {evt_level, evt_seq}, {m_level, m_seq[15:0]});
            end
        end
        check("rnd_drain", pend_t.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
